// File: rtl/axi_rd_arb_2to1.sv
// Two-client AXI4 read arbiter: round-robin AR issue with a registered
// master AR channel, and in-order R steering from a grant-order FIFO.
module axi_rd_arb_2to1 #(
    parameter int C_M_AXI_ID_WIDTH   = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_MAX_OUTSTANDING  = 8
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [7:0]                    s00_axi_arlen,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] s00_axi_rdata,
    output logic                          s00_axi_rlast,

    input  logic                          s01_axi_arvalid,
    output logic                          s01_axi_arready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] s01_axi_araddr,
    input  logic [7:0]                    s01_axi_arlen,
    output logic                          s01_axi_rvalid,
    input  logic                          s01_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] s01_axi_rdata,
    output logic                          s01_axi_rlast,

    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [1:0]                    m_axi_arburst,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                          m_axi_rlast,
    input  logic [1:0]                    m_axi_rresp,
    input  logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_rid
);

    localparam int PW = $clog2(C_MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    logic                          arvalid_q, arvalid_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]                    arlen_q, arlen_d;
    logic                          rr_q, rr_d;
    logic [C_MAX_OUTSTANDING-1:0]  order_q, order_d;
    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                 count_q, count_d;

    logic slot_free;
    logic accept;
    logic gnt;
    logic head;
    logic has_head;
    logic pop;
    logic unused_inputs;

    assign unused_inputs = ^{m_axi_rresp, m_axi_rid};

    // Grant and R steering; order FIFO bit is 1 when the burst belongs to s01.
    always_comb begin
        slot_free = !arvalid_q || m_axi_arready;
        accept    = !rst && slot_free && (count_q < CW'(C_MAX_OUTSTANDING))
                    && (s00_axi_arvalid || s01_axi_arvalid);
        gnt       = (s00_axi_arvalid && s01_axi_arvalid) ? rr_q : s01_axi_arvalid;

        s00_axi_arready = accept && !gnt;
        s01_axi_arready = accept && gnt;

        has_head = (count_q != '0);
        head     = order_q[rd_ptr_q];

        s00_axi_rvalid = has_head && !head && m_axi_rvalid;
        s01_axi_rvalid = has_head && head && m_axi_rvalid;
        m_axi_rready   = has_head && (head ? s01_axi_rready : s00_axi_rready);
        pop            = m_axi_rvalid && m_axi_rready && m_axi_rlast;
    end

    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        rr_d      = rr_q;
        order_d   = order_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (accept) begin
            arvalid_d         = 1'b1;
            araddr_d          = gnt ? s01_axi_araddr : s00_axi_araddr;
            arlen_d           = gnt ? s01_axi_arlen : s00_axi_arlen;
            rr_d              = !gnt;
            order_d[wr_ptr_q] = gnt;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end else if (arvalid_q && m_axi_arready) begin
            arvalid_d = 1'b0;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            rr_q      <= 1'b0;
            order_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            rr_q      <= rr_d;
            order_q   <= order_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arsize  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    assign m_axi_arid    = '0;

    assign s00_axi_rdata = m_axi_rdata;
    assign s01_axi_rdata = m_axi_rdata;
    assign s00_axi_rlast = m_axi_rlast;
    assign s01_axi_rlast = m_axi_rlast;

endmodule

// File: tb/tb_axi_rd_arb_2to1.sv
// Scoreboard bench for axi_rd_arb_2to1: client drivers, a read slave
// model, and a monitor that checks AR issue and R delivery order.
module tb_axi_rd_arb_2to1;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } req_t;

    typedef struct packed {
        logic        cl;
        logic [63:0] addr;
        logic [7:0]  len;
    } rexp_t;

    logic clk;
    logic rst;

    logic         cl_arvalid [2];
    logic         cl_arready [2];
    logic [63:0]  cl_araddr  [2];
    logic [7:0]   cl_arlen   [2];
    logic         cl_rvalid  [2];
    logic         cl_rready  [2];
    logic [511:0] cl_rdata   [2];
    logic         cl_rlast   [2];

    logic         m_arvalid;
    logic         m_arready;
    logic [63:0]  m_araddr;
    logic [1:0]   m_arburst;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;
    logic [3:0]   m_arid;
    logic         m_rvalid;
    logic         m_rready;
    logic [511:0] m_rdata;
    logic         m_rlast;
    logic [1:0]   m_rresp;
    logic [3:0]   m_rid;

    logic r_en;

    req_t  rq[2][$];
    req_t  exp_ar[$];
    rexp_t exp_r[$];
    req_t  sq[$];

    int checks = 0;
    int errors = 0;
    int mbeat  = 0;
    int cl_hs[2];

    axi_rd_arb_2to1 dut (
        .clk             (clk),
        .rst             (rst),
        .s00_axi_arvalid (cl_arvalid[0]),
        .s00_axi_arready (cl_arready[0]),
        .s00_axi_araddr  (cl_araddr[0]),
        .s00_axi_arlen   (cl_arlen[0]),
        .s00_axi_rvalid  (cl_rvalid[0]),
        .s00_axi_rready  (cl_rready[0]),
        .s00_axi_rdata   (cl_rdata[0]),
        .s00_axi_rlast   (cl_rlast[0]),
        .s01_axi_arvalid (cl_arvalid[1]),
        .s01_axi_arready (cl_arready[1]),
        .s01_axi_araddr  (cl_araddr[1]),
        .s01_axi_arlen   (cl_arlen[1]),
        .s01_axi_rvalid  (cl_rvalid[1]),
        .s01_axi_rready  (cl_rready[1]),
        .s01_axi_rdata   (cl_rdata[1]),
        .s01_axi_rlast   (cl_rlast[1]),
        .m_axi_arvalid   (m_arvalid),
        .m_axi_arready   (m_arready),
        .m_axi_araddr    (m_araddr),
        .m_axi_arburst   (m_arburst),
        .m_axi_arlen     (m_arlen),
        .m_axi_arsize    (m_arsize),
        .m_axi_arid      (m_arid),
        .m_axi_rvalid    (m_rvalid),
        .m_axi_rready    (m_rready),
        .m_axi_rdata     (m_rdata),
        .m_axi_rlast     (m_rlast),
        .m_axi_rresp     (m_rresp),
        .m_axi_rid       (m_rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Client AR driver: presents queued requests back to back.
    task automatic drv(input int c);
        logic hs;
        cl_arvalid[c] = 1'b0;
        cl_araddr[c]  = '0;
        cl_arlen[c]   = '0;
        forever begin
            @(negedge clk);
            hs = cl_arvalid[c] && cl_arready[c];
            @(posedge clk);
            #1;
            if (hs) void'(rq[c].pop_front());
            if (rq[c].size() > 0) begin
                cl_arvalid[c] = 1'b1;
                cl_araddr[c]  = rq[c][0].addr;
                cl_arlen[c]   = rq[c][0].len;
            end else begin
                cl_arvalid[c] = 1'b0;
            end
        end
    endtask

    initial drv(0);
    initial drv(1);

    // Read slave: returns bursts in AR order, beat data = {8{addr+beat}}.
    initial begin
        logic        ar_hs;
        logic        r_hs;
        logic [63:0] ar_a;
        logic [7:0]  ar_l;
        int          sbeat;
        sbeat    = 0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
        m_rid    = '0;
        forever begin
            @(negedge clk);
            ar_hs = m_arvalid && m_arready;
            ar_a  = m_araddr;
            ar_l  = m_arlen;
            r_hs  = m_rvalid && m_rready;
            @(posedge clk);
            #1;
            if (rst) begin
                sq.delete();
                sbeat    = 0;
                m_rvalid = 1'b0;
            end else begin
                if (ar_hs) sq.push_back('{addr: ar_a, len: ar_l});
                if (r_hs && sq.size() > 0) begin
                    if (sbeat == int'(sq[0].len)) begin
                        void'(sq.pop_front());
                        sbeat = 0;
                    end else begin
                        sbeat++;
                    end
                end
                m_rvalid = r_en && (sq.size() > 0);
                if (sq.size() > 0) begin
                    m_rdata = {8{sq[0].addr + 64'(sbeat)}};
                    m_rlast = (sbeat == int'(sq[0].len));
                end
            end
        end
    end

    // Monitor: pops and compares on every AR and client R handshake.
    always @(negedge clk) begin
        req_t  e;
        rexp_t r;
        if (rst) begin
            mbeat = 0;
        end else begin
            if (m_arvalid && m_arready) begin
                if (exp_ar.size() == 0) begin
                    chk("ar_unexpected", 1, 0);
                end else begin
                    e = exp_ar.pop_front();
                    chk("ar_addr", m_araddr, e.addr);
                    chk("ar_len", m_arlen, e.len);
                    chk("ar_id", m_arid, 0);
                    chk("ar_burst", m_arburst, 1);
                    chk("ar_size", m_arsize, 6);
                end
            end
            if (cl_rvalid[0] && cl_rvalid[1]) chk("r_both_valid", 1, 0);
            for (int c = 0; c < 2; c++) begin
                if (cl_arvalid[c] && cl_arready[c]) cl_hs[c]++;
                if (cl_rvalid[c] && cl_rready[c]) begin
                    if (exp_r.size() == 0) begin
                        chk("r_unexpected", 1, 0);
                    end else begin
                        r = exp_r[0];
                        chk("r_client", c, r.cl);
                        chk("r_data", cl_rdata[c], {8{r.addr + 64'(mbeat)}});
                        chk("r_last", cl_rlast[c], mbeat == int'(r.len));
                        if (mbeat >= int'(r.len)) begin
                            void'(exp_r.pop_front());
                            mbeat = 0;
                        end else begin
                            mbeat++;
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int c, input logic [63:0] a, input logic [7:0] l);
        rq[c].push_back('{addr: a, len: l});
        exp_ar.push_back('{addr: a, len: l});
        exp_r.push_back('{cl: c[0], addr: a, len: l});
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_r.size() != 0 || exp_ar.size() != 0 ||
                rq[0].size() != 0 || rq[1].size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, n >= 300, 0);
    endtask

    initial begin
        int n;
        int base;
        int pop_cyc;
        int acc_cyc;
        rst          = 1'b1;
        m_arready    = 1'b1;
        r_en         = 1'b1;
        cl_rready[0] = 1'b1;
        cl_rready[1] = 1'b1;
        cl_hs[0]     = 0;
        cl_hs[1]     = 0;

        repeat (2) @(negedge clk);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_araddr", m_araddr, 0);
        chk("rst_arlen", m_arlen, 0);
        chk("rst_rready", m_rready, 0);
        step();
        rst = 1'b0;
        repeat (2) step();

        // single read from s00
        issue(0, 64'h1000, 8'd3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cl_arvalid[0] && cl_arready[0]) && n < 20);
        chk("t1_grant_timeout", n >= 20, 0);
        @(negedge clk);
        chk("t1_arvalid", m_arvalid, 1);
        chk("t1_araddr", m_araddr, 64'h1000);
        chk("t1_arlen", m_arlen, 3);
        wait_done("t1");
        @(negedge clk);
        chk("t1_rready_idle", m_rready, 0);

        // AR backpressure then s01 rready toggling
        step();
        m_arready = 1'b0;
        issue(1, 64'h4000, 8'd5);
        n = 0;
        while (!m_arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_arvalid_timeout", n >= 20, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_arvalid", m_arvalid, 1);
            chk("t4_hold_araddr", m_araddr, 64'h4000);
            chk("t4_hold_arlen", m_arlen, 5);
        end
        step();
        m_arready = 1'b1;
        n = 0;
        while (exp_r.size() != 0 && n < 100) begin
            step();
            cl_rready[1] = ~cl_rready[1];
            @(negedge clk);
            if (m_rvalid) chk("t4_rready_mirror", m_rready, cl_rready[1]);
            n++;
        end
        chk("t4_timeout", n >= 100, 0);
        step();
        cl_rready[1] = 1'b1;

        // contention: alternates starting with s00
        step();
        for (int i = 0; i < 4; i++) begin
            issue(0, 64'h2000 + 64'(i) * 64'h200, 8'(i));
            issue(1, 64'h2100 + 64'(i) * 64'h200, 8'(3 - i));
        end
        wait_done("t2");

        // order FIFO full
        step();
        r_en = 1'b0;
        base = cl_hs[0];
        for (int i = 0; i < 9; i++) issue(0, 64'h3000 + 64'(i) * 64'h40, 8'd0);
        repeat (20) @(negedge clk);
        chk("t3_accepted", cl_hs[0] - base, 8);
        chk("t3_stall_arready", cl_arready[0], 0);
        step();
        r_en = 1'b1;
        pop_cyc = -1;
        acc_cyc = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (m_rvalid && m_rready && m_rlast && pop_cyc < 0) pop_cyc = k;
            if (cl_arvalid[0] && cl_arready[0] && acc_cyc < 0) acc_cyc = k;
        end
        chk("t3_pop_seen", pop_cyc >= 0, 1);
        chk("t3_accept_after_pop", acc_cyc, pop_cyc + 1);
        wait_done("t3");

        // reset in the middle of a burst
        step();
        issue(0, 64'h5000, 8'd7);
        n = 0;
        while (mbeat < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_beat_timeout", n >= 50, 0);
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_arvalid", m_arvalid, 0);
        chk("t5_rst_araddr", m_araddr, 0);
        chk("t5_rst_arlen", m_arlen, 0);
        chk("t5_rst_rready", m_rready, 0);
        chk("t5_rst_rvalid0", cl_rvalid[0], 0);
        exp_r.delete();
        exp_ar.delete();
        rq[0].delete();
        issue(1, 64'h6000, 8'd1);
        repeat (2) @(negedge clk);
        chk("t5_rst_arvalid_req", cl_arvalid[1], 1);
        chk("t5_rst_arready", cl_arready[1], 0);
        step();
        rst = 1'b0;
        wait_done("t5");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
